alu_src_a_arbiter: RTL and testbench

- Shares the multicycle CPU's ALU operand-A path between four requesters: PC-increment/branch unit, B-operand user, A-operand user and MDR-based user.
- Requester index i equals the AluSrcA mux select value i (0=PC, 1=B, 2=A, 3=MDR).
- The block grants the ALU to one requester at a time with round-robin fairness and drives AluSrcA for the whole operation.
- It holds the grant for a fixed number of ALU cycles, then pulses Done to the owner.

---
 rtl/alu_src_a_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_src_a_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_src_a_arbiter.sv
// Round-robin arbiter that hands the ALU operand-A path to one of four requesters
// and drives AluSrcA for the whole operation. Define ALU_ARB_LOCK_EN for Lock support.
module alu_src_a_arbiter #(
    parameter int OP_CYCLES = 2
`ifdef ALU_ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = 4
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Req,
`ifdef ALU_ARB_LOCK_EN
    input  logic       Lock,
`endif
    output logic [3:0] Grant,
    output logic [1:0] AluSrcA,
    output logic       AluStart,
    output logic [3:0] Done,
    output logic       Busy
);

    localparam int CNT_W = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OP_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       src_q, src_d;
    logic             start_q, start_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             relock;

`ifdef ALU_ARB_LOCK_EN
    localparam int LOCK_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

    // Extend the current owner only while it still wants the ALU and has lock budget left.
    assign relock = Lock && ((Req & grant_q) != 4'b0000)
                    && (lock_cnt_q < LOCK_W'(MAX_LOCK - 1));
`else
    assign relock = 1'b0;
`endif

    // Round-robin pick: scan downward so the smallest offset from ptr_q wins.
    logic       pick_valid;
    logic [1:0] pick_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (Req[ptr_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = ptr_q + 2'(k);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        src_d   = src_q;
        start_d = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
`ifdef ALU_ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    grant_d = 4'b0001 << pick_idx;
                    src_d   = pick_idx;
                    start_d = 1'b1;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (relock) begin
                    cnt_d   = CNT_LOAD;
                    start_d = 1'b1;
`ifdef ALU_ARB_LOCK_EN
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
`endif
                end else begin
                    // AluSrcA deliberately keeps the last owner's select after release.
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    ptr_d   = src_q + 2'd1;
`ifdef ALU_ARB_LOCK_EN
                    lock_cnt_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            src_q   <= 2'b00;
            start_q <= 1'b0;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
`ifdef ALU_ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            start_q <= start_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
`ifdef ALU_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign Grant    = grant_q;
    assign AluSrcA  = src_q;
    assign AluStart = start_q;
    assign Busy     = (state_q == BUSY);
    assign Done     = ((state_q == BUSY) && (cnt_q == '0)) ? grant_q : 4'b0000;

endmodule

// File: tb/tb_alu_src_a_arbiter.sv
// Bench for alu_src_a_arbiter: directed cycle tables plus random requesters against a
// transaction-level model. Define ALU_ARB_LOCK_EN to also cover locked operations.
module tb_alu_src_a_arbiter;

    localparam int OP = 2;
    localparam int ML = 4;
`ifdef ALU_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       lock;
    logic [3:0] grant;
    logic [1:0] alu_src_a;
    logic       alu_start;
    logic [3:0] done;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef ALU_ARB_LOCK_EN
    alu_src_a_arbiter #(.OP_CYCLES(OP), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset), .Req(req), .Lock(lock),
        .Grant(grant), .AluSrcA(alu_src_a), .AluStart(alu_start), .Done(done), .Busy(busy));
`else
    alu_src_a_arbiter #(.OP_CYCLES(OP)) dut (
        .clk(clk), .reset(reset), .Req(req),
        .Grant(grant), .AluSrcA(alu_src_a), .AluStart(alu_start), .Done(done), .Busy(busy));
`endif

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {4'b0, grant, alu_src_a, alu_start, done, busy};
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       lk;
        logic [3:0] g;
        logic [1:0] src;
        logic       st;
        logic [3:0] dn;
        logic       bz;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic [3:0] r, logic lk, logic [3:0] g,
                                logic [1:0] s, logic st, logic [3:0] d, logic b);
        vec_t v;
        v.rst = rst; v.req = r; v.lk = lk; v.g = g; v.src = s; v.st = st; v.dn = d; v.bz = b;
        vecs.push_back(v);
    endfunction

    // Idle cycle, start cycle, done cycle (OP = 2 means an operation is exactly start + done).
    function automatic void idl(logic [3:0] r, logic [1:0] s);
        add(1'b0, r, 1'b0, 4'b0000, s, 1'b0, 4'b0000, 1'b0);
    endfunction
    function automatic void stc(logic [3:0] r, logic [3:0] g, logic [1:0] s);
        add(1'b0, r, 1'b0, g, s, 1'b1, 4'b0000, 1'b1);
    endfunction
    function automatic void dnc(logic [3:0] r, logic [3:0] g, logic [1:0] s);
        add(1'b0, r, 1'b0, g, s, 1'b0, g, 1'b1);
    endfunction

    function automatic void build_table();
        // Idle with no requests.
        for (int i = 0; i < 5; i++) idl(4'b0000, 2'd0);
        // Single request from requester 2.
        idl(4'b0100, 2'd0); stc(4'b0100, 4'b0100, 2'd2); dnc(4'b0100, 4'b0100, 2'd2); idl(4'b0000, 2'd2);
        // Reset to bring ptr back to 0.
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0);
        // All four requesting, each dropping after its Done.
        idl(4'b1111, 2'd0); stc(4'b1111, 4'b0001, 2'd0); dnc(4'b1111, 4'b0001, 2'd0);
        idl(4'b1110, 2'd0); stc(4'b1110, 4'b0010, 2'd1); dnc(4'b1110, 4'b0010, 2'd1);
        idl(4'b1100, 2'd1); stc(4'b1100, 4'b0100, 2'd2); dnc(4'b1100, 4'b0100, 2'd2);
        idl(4'b1000, 2'd2); stc(4'b1000, 4'b1000, 2'd3); dnc(4'b1000, 4'b1000, 2'd3);
        idl(4'b0000, 2'd3);
        // Requester 1 first (ptr -> 2), then 3 and 1 held: expect 3,1,3.
        idl(4'b0010, 2'd3); stc(4'b1010, 4'b0010, 2'd1); dnc(4'b1010, 4'b0010, 2'd1);
        idl(4'b1010, 2'd1); stc(4'b1010, 4'b1000, 2'd3); dnc(4'b1010, 4'b1000, 2'd3);
        idl(4'b1010, 2'd3); stc(4'b1010, 4'b0010, 2'd1); dnc(4'b1010, 4'b0010, 2'd1);
        idl(4'b1010, 2'd1); stc(4'b1010, 4'b1000, 2'd3); dnc(4'b1010, 4'b1000, 2'd3);
        idl(4'b0000, 2'd3);
        // Move ptr to 3, grant requester 1, reset in its first cycle; ptr must restart at 0.
        idl(4'b0100, 2'd3); stc(4'b0100, 4'b0100, 2'd2); dnc(4'b0100, 4'b0100, 2'd2);
        idl(4'b0010, 2'd2);
        add(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1);
        idl(4'b1010, 2'd0); stc(4'b1010, 4'b0010, 2'd1); dnc(4'b1010, 4'b0010, 2'd1);
        idl(4'b0000, 2'd1);
`ifdef ALU_ARB_LOCK_EN
        // Locked: requester 0 gets ML back-to-back ops, then forced release to requester 1.
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0);
        add(1'b0, 4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < ML; i++) begin
            add(1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1);
            add(1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b0, 4'b0001, 1'b1);
        end
        idl(4'b0010, 2'd0); stc(4'b0010, 4'b0010, 2'd1); dnc(4'b0010, 4'b0010, 2'd1);
        idl(4'b0000, 2'd1);
`endif
    endfunction

    // ---------------- behavioural model ----------------
    bit m_busy, m_start;
    int m_owner, m_rem, m_ptr, m_src, m_locks;

    function automatic void model_reset();
        m_busy = 0; m_start = 0; m_owner = 0; m_rem = 0; m_ptr = 0; m_src = 0; m_locks = 0;
    endfunction

    function automatic logic [3:0] m_grant();
        return m_busy ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    function automatic logic [15:0] model_outs();
        logic [3:0] g;
        logic [3:0] d;
        g = m_grant();
        d = (m_busy && m_rem == 0) ? g : 4'b0000;
        return {4'b0, g, 2'(m_src), m_start, d, m_busy};
    endfunction

    function automatic void model_step(bit rst, logic [3:0] r, bit lk);
        bit found;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            m_start = 0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr + k) % 4]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % 4;
                end
            end
            if (found) begin
                m_busy = 1; m_src = m_owner; m_rem = OP - 1; m_start = 1;
            end
        end else begin
            m_start = 0;
            if (m_rem > 0) begin
                m_rem--;
            end else if (LOCK_EN && lk && r[m_owner] && m_locks < ML - 1) begin
                m_rem = OP - 1; m_start = 1; m_locks++;
            end else begin
                m_busy = 0; m_ptr = (m_owner + 1) % 4; m_locks = 0;
            end
        end
    endfunction

    // ---------------- stimulus ----------------
    int waits[4];

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        lock  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs(), 16'h0000);
        reset = 1'b0;

        build_table();
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            check($sformatf("vec%0d", k), outs(),
                  {4'b0, vecs[k].g, vecs[k].src, vecs[k].st, vecs[k].dn, vecs[k].bz});
            reset = vecs[k].rst;
            req   = vecs[k].req;
            lock  = vecs[k].lk;
        end

        // Random requesters that hold Req until Done, with occasional resets.
        @(negedge clk);
        reset = 1'b1; req = 4'b0000; lock = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [15:0] exp;
            @(negedge clk);
            exp = model_outs();
            check($sformatf("rand_c%0d", cyc), outs(), exp);
            check($sformatf("onehot_c%0d", cyc), 16'($onehot0(grant)), 16'd1);
            check($sformatf("done_sub_c%0d", cyc), 16'(done & ~grant), 16'd0);
`ifndef ALU_ARB_LOCK_EN
            if (alu_start === 1'b1) begin
                for (int j = 0; j < 4; j++) begin
                    if (j == int'(alu_src_a)) waits[j] = 0;
                    else if (req[j]) waits[j]++;
                    check($sformatf("fair_r%0d_c%0d", j, cyc), 16'(waits[j] <= 3), 16'd1);
                end
            end
`endif
            reset = ($urandom_range(0, 59) == 0);
            for (int j = 0; j < 4; j++) begin
                if (req[j] && exp[1 + j]) req[j] = 1'b0;
                else if (!req[j] && $urandom_range(0, 2) == 0) req[j] = 1'b1;
            end
            lock = 1'($urandom_range(0, 1));
            if (reset) for (int j = 0; j < 4; j++) waits[j] = 0;
            model_step(reset, req, lock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
